// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - run sequencer for an external up/down binary counter
// Loads the counter, counts up to a limit, pauses, counts back down to zero, then pulses done.
module counter_sequencer #(
   parameter int N  = 8,
   parameter int HW = 8
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_start,
   input  logic          i_abort,
   input  logic [N-1:0]  i_load_val,
   input  logic [N-1:0]  i_limit,
   input  logic [HW-1:0] i_hold_cycles,
   input  logic [N-1:0]  i_cnt,
   output logic          o_ce,
   output logic          o_we,
   output logic [N-1:0]  o_data,
   output logic          o_count_up,
   output logic          o_count_down,
   output logic          o_busy,
   output logic          o_done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_UP   = 3'd2,
      S_HOLD = 3'd3,
      S_DOWN = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  load_q, load_d;
   logic [N-1:0]  limit_q, limit_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= S_IDLE;
         load_q     <= '0;
         limit_q    <= '0;
         hold_q     <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         load_q     <= load_d;
         limit_q    <= limit_d;
         hold_q     <= hold_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      load_d     = load_q;
      limit_d    = limit_q;
      hold_d     = hold_q;
      hold_cnt_d = hold_cnt_q;
      if (i_abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  load_d  = i_load_val;
                  limit_d = i_limit;
                  hold_d  = i_hold_cycles;
                  state_d = S_LOAD;
               end
            end
            S_LOAD: begin
               if (limit_q > load_q) begin
                  state_d = S_UP;
               end else begin
                  state_d    = S_HOLD;
                  hold_cnt_d = hold_q;
               end
            end
            S_UP: begin
               if (i_cnt == limit_q) begin
                  state_d    = S_HOLD;
                  hold_cnt_d = hold_q;
               end
            end
            S_HOLD: begin
               // A zero hold count still spends one cycle here.
               if (hold_cnt_q <= HW'(1)) begin
                  state_d = S_DOWN;
               end else begin
                  hold_cnt_d = hold_cnt_q - HW'(1);
               end
            end
            S_DOWN: begin
               if (i_cnt == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_busy       = (state_q != S_IDLE);
      o_ce         = (state_q != S_IDLE);
      o_we         = (state_q == S_LOAD);
      o_data       = load_q;
      o_count_up   = (state_q == S_UP) && (i_cnt != limit_q);
      o_count_down = (state_q == S_DOWN) && (i_cnt != '0);
      o_done       = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - bench for counter_sequencer driving a behavioural binary counter
// Run statistics are compared against totals derived arithmetically from load, limit and hold.
module tb_counter_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] load_val = '0;
   logic [7:0] limit = '0;
   logic [7:0] hold = '0;
   logic [7:0] cnt_m = '0;
   logic       ce, we, up, down, busy, done;
   logic [7:0] data;

   int n_pass = 0;
   int n_chk  = 0;

   int st_busy, st_up, st_down, st_we, st_done, st_max, st_after_busy;
   bit st_excl_ok, st_data_ok, st_timeout;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ce) begin
         if (we)        cnt_m <= data;
         else if (up)   cnt_m <= cnt_m + 8'd1;
         else if (down) cnt_m <= cnt_m - 8'd1;
      end
   end

   counter_sequencer #(.N(8), .HW(8)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort),
      .i_load_val(load_val), .i_limit(limit), .i_hold_cycles(hold), .i_cnt(cnt_m),
      .o_ce(ce), .o_we(we), .o_data(data), .o_count_up(up), .o_count_down(down),
      .o_busy(busy), .o_done(done)
   );

   function automatic int exp_peak(int ld, int lim);
      return (lim > ld) ? lim : ld;
   endfunction
   function automatic int exp_up(int ld, int lim);
      return (lim > ld) ? lim - ld : 0;
   endfunction
   function automatic int exp_busy(int ld, int lim, int hd);
      int up_cycles = (lim > ld) ? lim - ld + 1 : 0;
      int hold_len  = (hd == 0) ? 1 : hd;
      return 1 + up_cycles + hold_len + exp_peak(ld, lim) + 1 + 1;
   endfunction

   // Starts one run at a negedge and gathers per-cycle statistics until done.
   task automatic run_one(input logic [7:0] ld, input logic [7:0] lim,
                          input logic [7:0] hd, input bit noise);
      bit fin = 0;
      st_busy = 0; st_up = 0; st_down = 0; st_we = 0; st_done = 0; st_max = 0;
      st_excl_ok = 1; st_data_ok = 1; st_timeout = 0; st_after_busy = 0;
      load_val = ld; limit = lim; hold = hd; start = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 3000 && !fin; c++) begin
         if (busy) st_busy++;
         if (we) begin
            st_we++;
            if (data !== ld) st_data_ok = 0;
         end
         if (up) st_up++;
         if (down) st_down++;
         if (up && down) st_excl_ok = 0;
         if (int'(cnt_m) > st_max) st_max = int'(cnt_m);
         if (done) begin
            st_done++;
            fin = 1;
            start = 1'b0;
         end else begin
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         @(negedge clk);
      end
      if (!fin) st_timeout = 1;
      start = 1'b0;
      st_after_busy = int'(busy);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({ce, we, up, down, busy, done} !== 6'b0) $display("FAIL reset_ctrl: got %b want 000000", {ce, we, up, down, busy, done});
      else n_pass++;
      n_chk++;
      if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data);
      else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_nominal();
      run_one(8'h2F, 8'h39, 8'd2, 1'b0);
      n_chk++;
      if (st_timeout || st_busy !== exp_busy(8'h2F, 8'h39, 2)) $display("FAIL nominal_busy: got %0d want %0d (timeout=%0d)", st_busy, exp_busy(8'h2F, 8'h39, 2), st_timeout);
      else n_pass++;
      n_chk++;
      if (st_up !== 10 || st_down !== 8'h39) $display("FAIL nominal_updown: got up=%0d down=%0d want up=10 down=57", st_up, st_down);
      else n_pass++;
      n_chk++;
      if (st_we !== 1 || st_done !== 1 || !st_data_ok) $display("FAIL nominal_we_done: got we=%0d done=%0d data_ok=%0d want 1 1 1", st_we, st_done, st_data_ok);
      else n_pass++;
      n_chk++;
      if (st_max !== 8'h39 || cnt_m !== 8'h00 || st_after_busy !== 0) $display("FAIL nominal_range: got max=%h end=%h busy_after=%0d want 39 00 0", st_max, cnt_m, st_after_busy);
      else n_pass++;
   endtask

   task automatic test_limit_below_load();
      run_one(8'h10, 8'h05, 8'd0, 1'b0);
      n_chk++;
      if (st_busy !== exp_busy(8'h10, 8'h05, 0) || st_up !== 0 || st_down !== 16 || st_done !== 1) $display("FAIL limit_below: got busy=%0d up=%0d down=%0d done=%0d want %0d 0 16 1", st_busy, st_up, st_down, st_done, exp_busy(8'h10, 8'h05, 0));
      else n_pass++;
   endtask

   task automatic test_zero_run();
      run_one(8'h00, 8'h00, 8'd0, 1'b0);
      n_chk++;
      if (st_busy !== 4 || st_up !== 0 || st_down !== 0 || st_max !== 0 || st_done !== 1) $display("FAIL zero_run: got busy=%0d up=%0d down=%0d max=%0d done=%0d want 4 0 0 0 1", st_busy, st_up, st_down, st_max, st_done);
      else n_pass++;
   endtask

   task automatic test_abort_up();
      int seen_done = 0;
      bit hit = 0;
      load_val = 8'h30; limit = 8'h40; hold = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin
         if (done) seen_done++;
         if (cnt_m == 8'h32 && up) hit = 1;
         else @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_chk++;
      if (!hit || {ce, we, up, down, busy, done} !== 6'b0) $display("FAIL abort_ctrl: got %b hit=%0d want 000000 hit=1", {ce, we, up, down, busy, done}, hit);
      else n_pass++;
      repeat (3) begin
         if (done) seen_done++;
         @(negedge clk);
      end
      n_chk++;
      if (cnt_m !== 8'h33 || seen_done !== 0) $display("FAIL abort_hold: got cnt=%h done_pulses=%0d want 33 0", cnt_m, seen_done);
      else n_pass++;
   endtask

   task automatic test_abort_vs_start();
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || we !== 1'b0) $display("FAIL abort_start_idle: got busy=%b we=%b want 0 0", busy, we);
      else n_pass++;
   endtask

   task automatic test_reset_mid_hold();
      int seen_done = 0;
      load_val = 8'h05; limit = 8'h05; hold = 8'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({ce, we, up, down, busy, done} !== 6'b0 || data !== 8'h00) $display("FAIL async_reset: got ctrl=%b data=%h want 000000 00", {ce, we, up, down, busy, done}, data);
      else n_pass++;
      @(negedge clk);
      if (done) seen_done++;
      rst_n = 1'b1;
      run_one(8'h05, 8'h09, 8'd1, 1'b0);
      n_chk++;
      if (seen_done !== 0 || st_busy !== exp_busy(5, 9, 1) || st_done !== 1) $display("FAIL reset_rerun: got busy=%0d done=%0d early_done=%0d want %0d 1 0", st_busy, st_done, seen_done, exp_busy(5, 9, 1));
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int n_done = 0, n_we = 0, n_idle = 0;
      int per_run = exp_busy(2, 4, 1) + 1;
      load_val = 8'h02; limit = 8'h04; hold = 8'd1; start = 1'b1;
      for (int c = 0; c < 3 * per_run; c++) begin
         @(negedge clk);
         if (done) n_done++;
         if (we) n_we++;
         if (!busy) n_idle++;
      end
      start = 1'b0;
      @(negedge clk);
      n_chk++;
      if (n_done !== 3 || n_we !== 3 || n_idle !== 3) $display("FAIL back_to_back: got done=%0d we=%0d idle=%0d want 3 3 3", n_done, n_we, n_idle);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         logic [7:0] ld = 8'($urandom_range(0, 255));
         logic [7:0] lm = 8'($urandom_range(0, 255));
         logic [7:0] hd = 8'($urandom_range(0, 5));
         run_one(ld, lm, hd, 1'b1);
         n_chk++;
         if (st_timeout || st_busy !== exp_busy(ld, lm, hd) || st_after_busy !== 0) $display("FAIL rand%0d_busy: got %0d want %0d (ld=%h lim=%h hold=%0d)", i, st_busy, exp_busy(ld, lm, hd), ld, lm, hd);
         else n_pass++;
         n_chk++;
         if (st_up !== exp_up(ld, lm) || st_down !== exp_peak(ld, lm)) $display("FAIL rand%0d_updown: got up=%0d down=%0d want %0d %0d", i, st_up, st_down, exp_up(ld, lm), exp_peak(ld, lm));
         else n_pass++;
         n_chk++;
         if (st_we !== 1 || st_done !== 1 || !st_data_ok || !st_excl_ok) $display("FAIL rand%0d_strobes: got we=%0d done=%0d data_ok=%0d excl_ok=%0d want 1 1 1 1", i, st_we, st_done, st_data_ok, st_excl_ok);
         else n_pass++;
         n_chk++;
         if (st_max !== exp_peak(ld, lm) || cnt_m !== 8'h00) $display("FAIL rand%0d_range: got max=%0d end=%0d want %0d 0", i, st_max, cnt_m, exp_peak(ld, lm));
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_limit_below_load();
      test_zero_run();
      test_abort_up();
      test_abort_vs_start();
      test_reset_mid_hold();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
